// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush (NOP insert) and step-gated advance.
// Optional performance counters (o_stall_cnt, o_flush_cnt) when IF_ID_PERF_CNT_EN is defined.
module if_id_stage #(
    parameter int              NB     = 32,
    parameter int              NB_REG = 5,
    parameter logic [NB-1:0]   NOP    = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic [NB-1:0]     i_IF_pc,
    input  logic [NB-1:0]     i_IF_pc4,
    input  logic [NB-1:0]     i_IF_pc8,
    input  logic [NB-1:0]     i_instruction,
    input  logic              i_flush,
    input  logic              i_ID_EX_mem_read,
    input  logic [NB_REG-1:0] i_ID_EX_rt,
    output logic              o_pc_write,
    output logic              o_bubble,
    output logic [NB-1:0]     o_ID_pc,
    output logic [NB-1:0]     o_ID_pc4,
    output logic [NB-1:0]     o_ID_pc8,
    output logic [NB-1:0]     o_ID_instruction,
    output logic              o_ID_valid
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [NB-1:0]     o_stall_cnt,
    output logic [NB-1:0]     o_flush_cnt
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [NB-1:0]     r_pc;
    logic [NB-1:0]     r_pc4;
    logic [NB-1:0]     r_pc8;
    logic [NB-1:0]     r_instr;
    logic              r_valid;
    logic [NB_REG-1:0] w_rs;
    logic [NB_REG-1:0] w_rt;
    logic              w_hazard;
    logic              w_stall_evt;

    assign w_rs = r_instr[25:21];
    assign w_rt = r_instr[20:16];

    // STALL suppresses the hazard so each load-use pair costs exactly one bubble.
    assign w_hazard = r_valid & i_ID_EX_mem_read & (i_ID_EX_rt != '0)
                    & ((i_ID_EX_rt == w_rs) | (i_ID_EX_rt == w_rt))
                    & (r_state == RUN);

    assign w_stall_evt = i_step & w_hazard & ~i_flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (i_step) begin
            case (r_state)
                RUN:     w_next_state = w_stall_evt ? STALL : RUN;
                STALL:   w_next_state = RUN;
                default: w_next_state = RUN;
            endcase
        end
    end

    always_comb begin
        o_pc_write = ~w_hazard | i_flush;
        o_bubble   = w_hazard & ~i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_pc8   <= '0;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_step) begin
            if (i_flush) begin
                r_pc    <= i_IF_pc;
                r_pc4   <= i_IF_pc4;
                r_pc8   <= i_IF_pc8;
                r_instr <= NOP;
                r_valid <= 1'b0;
            end else if (!w_hazard) begin
                r_pc    <= i_IF_pc;
                r_pc4   <= i_IF_pc4;
                r_pc8   <= i_IF_pc8;
                r_instr <= i_instruction;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_ID_pc          = r_pc;
    assign o_ID_pc4         = r_pc4;
    assign o_ID_pc8         = r_pc8;
    assign o_ID_instruction = r_instr;
    assign o_ID_valid       = r_valid;

`ifdef IF_ID_PERF_CNT_EN
    logic [NB-1:0] r_stall_cnt;
    logic [NB-1:0] r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt)        r_stall_cnt <= r_stall_cnt + 1'b1;
            if (i_step && i_flush)  r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        i_reset, i_step, i_flush, i_mr;
    logic [31:0] i_pc, i_pc4, i_pc8, i_instr;
    logic [4:0]  i_rt;
    logic        o_pc_write, o_bubble, o_valid;
    logic [31:0] o_pc, o_pc4, o_pc8, o_instr;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: what decode should currently see.
    logic [31:0] m_pc, m_pc4, m_pc8, m_instr;
    logic        m_valid;
    logic        m_bubbled;   // current slot already produced its one bubble
    logic        m_known = 1'b0;
    int unsigned m_stalls, m_flushes;

    always #5 clk = ~clk;

    if_id_stage dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_step           (i_step),
        .i_IF_pc          (i_pc),
        .i_IF_pc4         (i_pc4),
        .i_IF_pc8         (i_pc8),
        .i_instruction    (i_instr),
        .i_flush          (i_flush),
        .i_ID_EX_mem_read (i_mr),
        .i_ID_EX_rt       (i_rt),
        .o_pc_write       (o_pc_write),
        .o_bubble         (o_bubble),
        .o_ID_pc          (o_pc),
        .o_ID_pc4         (o_pc4),
        .o_ID_pc8         (o_pc8),
        .o_ID_instruction (o_instr),
        .o_ID_valid       (o_valid)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .o_stall_cnt      (o_stall_cnt),
        .o_flush_cnt      (o_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Load-use rule evaluated on the decoded fields of the instruction sitting in ID.
    function automatic logic model_hazard();
        logic [4:0] rs, rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        return m_valid && i_mr && (i_rt != 0) && (i_rt == rs || i_rt == rt) && !m_bubbled;
    endfunction

    task automatic cyc(input logic rst, input logic step, input logic flush, input logic mr,
                       input logic [4:0] rt, input logic [31:0] pc, input logic [31:0] instr);
        logic haz;
        i_reset = rst; i_step = step; i_flush = flush; i_mr = mr; i_rt = rt;
        i_pc = pc; i_pc4 = pc + 32'd4; i_pc8 = pc + 32'd8; i_instr = instr;
        @(negedge clk);
        haz = model_hazard();
        if (m_known) begin
            check("pc_write", {31'd0, o_pc_write}, {31'd0, !haz || flush});
            check("bubble",   {31'd0, o_bubble},   {31'd0, haz && !flush});
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_pc4 = 0; m_pc8 = 0; m_instr = 0; m_valid = 0; m_bubbled = 0;
            m_stalls = 0; m_flushes = 0; m_known = 1'b1;
        end else if (step && m_known) begin
            if (flush) begin
                m_pc = pc; m_pc4 = pc + 4; m_pc8 = pc + 8; m_instr = 0; m_valid = 0; m_bubbled = 0;
                m_flushes++;
            end else if (haz) begin
                m_bubbled = 1;
                m_stalls++;
            end else begin
                m_pc = pc; m_pc4 = pc + 4; m_pc8 = pc + 8; m_instr = instr; m_valid = 1; m_bubbled = 0;
            end
        end
        #1;
        check("ID_pc",    o_pc,    m_pc);
        check("ID_pc4",   o_pc4,   m_pc4);
        check("ID_pc8",   o_pc8,   m_pc8);
        check("ID_instr", o_instr, m_instr);
        check("ID_valid", {31'd0, o_valid}, {31'd0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt", o_stall_cnt, m_stalls);
        check("flush_cnt", o_flush_cnt, m_flushes);
`endif
    endtask

    initial begin
        i_reset = 1; i_step = 0; i_flush = 0; i_mr = 0; i_rt = 0;
        i_pc = 0; i_pc4 = 0; i_pc8 = 0; i_instr = 0;
        @(posedge clk); #1;

        // Reset, then first fetch lands in decode one step later.
        cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc(0, 1, 0, 0, 0, 32'h10, 32'h8C22_0004);
        check("first_pc8", o_pc8, 32'h18);

        // Frozen while not stepping, despite changing inputs and a would-be hazard.
        for (int i = 0; i < 5; i++)
            cyc(0, 0, i[0], 1, 5'd1, 32'h100 + 32'(i * 4), $urandom);

        // add $3,$1,$2 in ID, load to $1 in EX: one bubble, then release.
        cyc(0, 1, 0, 0, 0, 32'h14, 32'h0022_1820);
        cyc(0, 1, 0, 1, 5'd1, 32'h18, 32'h1111_1111);
        check("stall_pc_hold", o_pc, 32'h14);
        cyc(0, 1, 0, 1, 5'd1, 32'h18, 32'h2222_2222);
        check("release_pc", o_pc, 32'h18);

        // Load into $0 never stalls.
        cyc(0, 1, 0, 0, 0, 32'h20, 32'h0000_0020);
        cyc(0, 1, 0, 1, 5'd0, 32'h24, 32'h0000_0024);

        // Flush beats hazard.
        cyc(0, 1, 0, 0, 0, 32'h30, 32'h0022_1820);
        cyc(0, 1, 1, 1, 5'd2, 32'h34, 32'hDEAD_BEEF);

        // Reset while stalled with no step, then normal step.
        cyc(0, 1, 0, 0, 0, 32'h40, 32'h0022_1820);
        cyc(0, 1, 0, 1, 5'd2, 32'h44, 32'h0);
        cyc(1, 0, 0, 1, 5'd2, 32'h48, 32'h0);
        cyc(0, 1, 0, 1, 5'd2, 32'h4C, 32'h0022_1820);

        // Random traffic with register fields in a small range to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, ins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
